// File: rtl/stats_bram_writer_pkg.sv
// Shared constants and types for the stats BRAM writer: header layout and FSM states.
package stats_pkg;

    localparam logic [15:0] STATS_MAGIC = 16'h5354;

    // Header word layout: magic [63:48], seq [47:32], count [31:0]
    localparam int HDR_MAGIC_LSB = 48;
    localparam int HDR_SEQ_LSB   = 32;
    localparam int HDR_CNT_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_HEADER = 2'd2,
        ST_DONE   = 2'd3
    } stats_wr_state_t;

    function automatic logic [63:0] make_header(input logic [15:0] seq_v, input logic [31:0] cnt_v);
        logic [63:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 16] = STATS_MAGIC;
        h[HDR_SEQ_LSB   +: 16] = seq_v;
        h[HDR_CNT_LSB   +: 32] = cnt_v;
        return h;
    endfunction

endpackage

// File: rtl/stats_bram_writer_counter_bank.sv
// Live event counters plus a shadow copy taken on snapshot; one indexed read port
// that returns either a live or a shadow value, zero-extended to 64 bits.
module stats_counter_bank #(
    parameter int N     = 32,
    parameter int CNT_W = 64,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  ev_inc,
    input  logic          snapshot,
    input  logic          clear,
    input  logic          rd_live,
    input  logic [IW-1:0] rd_idx,
    output logic [63:0]   rd_data
);

    logic [CNT_W-1:0] cnt    [N];
    logic [CNT_W-1:0] shadow [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (snapshot)
                    shadow[i] <= cnt[i];
                // On a clearing snapshot the coincident increment is the first event of the new epoch.
                if (snapshot && clear)
                    cnt[i] <= CNT_W'(ev_inc[i]);
                else
                    cnt[i] <= cnt[i] + CNT_W'(ev_inc[i]);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < N)
            rd_data = 64'(rd_live ? cnt[rd_idx] : shadow[rd_idx]);
    end

endmodule

// File: rtl/stats_bram_writer.sv
// Event-statistics collector: snapshots all counters on a dump request and streams them
// into BRAM port A, header word (with sequence number) last so the host sees complete records.
module stats_bram_writer
    import stats_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_W      = 64,
    parameter int ADDR_W     = 16,
    parameter int BASE_ADDR  = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES*NUM_EVENTS-1:0] ev_inc,
    input  logic                            dump_req,
    input  logic                            clear_on_dump,
    output logic                            busy,
    output logic                            done,
    output logic [15:0]                     seq,
    output logic                            bram_en_a,
    output logic [7:0]                      bram_we_a,
    output logic [ADDR_W-1:0]               bram_addr_a,
    output logic [63:0]                     bram_wdata_a
);

    localparam int N  = NUM_CORES * NUM_EVENTS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (longint'(BASE_ADDR) + longint'(N) > (longint'(1) << ADDR_W) - 1) begin : g_addr_chk
        $error("stats_bram_writer: BASE_ADDR+N does not fit in ADDR_W");
    end
    if (CNT_W < 1 || CNT_W > 64) begin : g_cnt_chk
        $error("stats_bram_writer: CNT_W must be 1..64");
    end

    stats_wr_state_t state;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            rd_live;
    logic [IW-1:0]   rd_idx;
    logic [63:0]     rd_data;

    assign accept  = (state == ST_IDLE) && dump_req;
    // Outputs are registered, so the bank is read one entry ahead: live counter 0 on the
    // accept edge (same value the shadow captures), then shadow[idx+1] while writing.
    assign rd_live = (state == ST_IDLE);
    assign rd_idx  = (state == ST_IDLE) ? '0 : idx + IW'(1);

    stats_counter_bank #(
        .N     (N),
        .CNT_W (CNT_W),
        .IW    (IW)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .ev_inc   (ev_inc),
        .snapshot (accept),
        .clear    (clear_on_dump),
        .rd_live  (rd_live),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            seq          <= '0;
            bram_en_a    <= 1'b0;
            bram_we_a    <= '0;
            bram_addr_a  <= '0;
            bram_wdata_a <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dump_req) begin
                        state        <= ST_WRITE;
                        idx          <= '0;
                        busy         <= 1'b1;
                        bram_en_a    <= 1'b1;
                        bram_we_a    <= 8'hFF;
                        bram_addr_a  <= ADDR_W'(BASE_ADDR + 1);
                        bram_wdata_a <= rd_data;
                    end
                end
                ST_WRITE: begin
                    if (idx == IW'(N - 1)) begin
                        state        <= ST_HEADER;
                        bram_addr_a  <= ADDR_W'(BASE_ADDR);
                        bram_wdata_a <= make_header(seq + 16'd1, 32'(N));
                    end else begin
                        idx          <= idx + IW'(1);
                        bram_addr_a  <= bram_addr_a + ADDR_W'(1);
                        bram_wdata_a <= rd_data;
                    end
                end
                ST_HEADER: begin
                    state        <= ST_DONE;
                    done         <= 1'b1;
                    bram_en_a    <= 1'b0;
                    bram_we_a    <= '0;
                    bram_addr_a  <= '0;
                    bram_wdata_a <= '0;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    seq   <= seq + 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/stats_bram_writer.md
Name: stats_bram_writer

Overview:
- Per-core event-statistics collector; the write side of the stats dual-port BRAM whose port B the host reads.
- Holds NUM_CORES x NUM_EVENTS free-running counters.
- On a dump request, snapshots all counters and streams them into BRAM port A, then writes a header word carrying a sequence number.
- The header is written last, so a host that sees a new sequence number knows the whole record is complete.

Parameters:
- NUM_CORES, 4, number of cores reporting events.
- NUM_EVENTS, 8, event types per core.
- CNT_W, 64, counter width in bits (1..64); zero-extended to 64 on write.
- ADDR_W, 16, BRAM port-A word-address width.
- BASE_ADDR, 0, word address of the header; counters follow at BASE_ADDR+1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- ev_inc  in  NUM_CORES*NUM_EVENTS  per-counter increment strobe; index = core*NUM_EVENTS+event.
- dump_req  in  1  dump request, level-sampled only in IDLE.
- clear_on_dump  in  1  sampled with an accepted dump_req; when high, live counters restart from the snapshot point.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the header write.
- seq  out  16  number of completed dumps (mod 2^16).
- bram_en_a  out  1  port-A enable.
- bram_we_a  out  8  byte write enables (all 1s or all 0s).
- bram_addr_a  out  ADDR_W  port-A word address.
- bram_wdata_a  out  64  port-A write data.

Behaviour:
- Reset (synchronous, active-high, clk):
  - all counters, shadow registers and seq = 0; state = IDLE.
  - busy = 0, done = 0, bram_en_a = 0, bram_we_a = 0, bram_addr_a = 0, bram_wdata_a = 0.
  - A reset mid-dump aborts immediately; no further BRAM writes and no done pulse.
- All outputs are registered.
- N = NUM_CORES*NUM_EVENTS.
- Counters:
  - each cycle, counter[i] += ev_inc[i] (at most +1 per cycle);
  - wrap modulo 2^CNT_W, no saturation.
- States: IDLE, WRITE, HEADER, DONE.
- IDLE:
  - if dump_req, then on that edge: shadow[i] <= counter[i] for all i; idx <= 0; state <= WRITE.
  - If clear_on_dump was also high, counter[i] <= ev_inc[i] on the same edge, so an increment coincident with the snapshot is not lost and not double-counted.
  - Otherwise counters continue normally.
- WRITE (N cycles, idx = 0..N-1):
  - bram_en_a = 1, bram_we_a = 8'hFF, bram_addr_a = BASE_ADDR+1+idx, bram_wdata_a = zero-extended shadow[idx].
  - After idx = N-1, state <= HEADER.
- HEADER (1 cycle):
  - bram_en_a = 1, we = FF, addr = BASE_ADDR.
  - wdata = {16'h5354 magic, seq+1 (16), N (32)}.
- DONE (1 cycle):
  - done = 1, seq <= seq+1 (wraps 16'hFFFF -> 0), BRAM outputs deasserted; state <= IDLE.
- dump_req outside IDLE is ignored; it is not queued.
- Live counters keep counting during WRITE, HEADER and DONE.
- Address arithmetic is truncated to ADDR_W; elaboration fails if BASE_ADDR+N exceeds 2^ADDR_W-1.
- Timing, request accepted at edge E0:
  - first counter write is visible in the cycle after E0;
  - header write in cycle N+1; done in cycle N+2;
  - next request accepted at the edge ending cycle N+3.
- busy is high from the cycle after E0 through the DONE cycle inclusive.

Decomposition:
- Package stats_pkg holds:
  - STATS_MAGIC = 16'h5354;
  - header field positions: magic [63:48], seq [47:32], count [31:0];
  - the state enum typedef stats_wr_state_t.
- One sub-module, stats_counter_bank, holds the live counters and shadow registers, with snapshot/clear controls and an indexed shadow read.
- The top module holds the FSM and the BRAM drive.

Test Plan:
- Reset: hold reset 3 cycles -> all outputs 0, seq = 0. A dump with no events -> addresses 1..32 written with 0, then addr 0 = 64'h5354_0001_0000_0020, then done.
- Counting: pulse ev_inc[0] 5 times and ev_inc[31] 3 times, then dump -> addr 1 = 5, addr 32 = 3, all others 0. Header is written after all counter writes; done occurs at cycle 34 after acceptance.
- clear_on_dump: 4 events on ctr 2, dump with clear = 1 while ev_inc[2] is high on the accept edge. Add 2 more events during the dump, then dump again -> first dump addr 3 = 4; second dump addr 3 = 3; seq = 2.
- Busy rejection: hold dump_req high continuously -> exactly one dump per 35-cycle period, with no writes overlapping a dump.
- Reset mid-dump: assert reset in WRITE at idx = 10 -> BRAM enable drops the next cycle, no header write, no done pulse, seq = 0.
- Wrap: CNT_W = 8, 257 events on ctr 0, then dump -> addr 1 = 64'h1. Then set seq to 16'hFFFF via 65535 prior dumps (force) -> header seq field 0.
